// File: rtl/int_to_fp32_seq_if.sv
// Handshake bundle for the integer-to-fp32 encoder: input stream (integer operand)
// and output stream (packed fp32 word plus inexact flag).
interface int_to_fp32_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_inexact;

    modport master (
        output in_valid, in_data, in_signed, out_ready,
        input  in_ready, out_valid, out_data, out_inexact
    );

    modport slave (
        input  in_valid, in_data, in_signed, out_ready,
        output in_ready, out_valid, out_data, out_inexact
    );
endinterface

// File: rtl/int_to_fp32_seq.sv
// Sequential signed/unsigned 32-bit integer to fp32 encoder, round-to-nearest-even,
// with iterative left-shift normalisation and valid/ready on both sides.
module int_to_fp32_seq #(
    parameter int SHIFT_STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    int_to_fp32_seq_if.slave  bus
);
    generate
        if (!(SHIFT_STEP == 1 || SHIFT_STEP == 2 || SHIFT_STEP == 4 || SHIFT_STEP == 8)) begin : g_bad_step
            $error("int_to_fp32_seq: SHIFT_STEP must be 1, 2, 4 or 8");
        end
    endgenerate

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t      r_state;
    logic [31:0] r_mag;
    logic [4:0]  r_cnt;
    logic        r_sign;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic        r_out_inexact;

    logic        w_coarse;
    logic [22:0] w_frac;
    logic        w_guard;
    logic        w_sticky;
    logic        w_up;
    logic [23:0] w_frac_rnd;
    logic [7:0]  w_exp;

    // Coarse shift is only safe when the whole top window is clear, so cnt stays <= 31.
    assign w_coarse   = (r_mag[31:32-SHIFT_STEP] == '0);
    assign w_frac     = r_mag[30:8];
    assign w_guard    = r_mag[7];
    assign w_sticky   = |r_mag[6:0];
    assign w_up       = w_guard & (w_sticky | w_frac[0]);
    assign w_frac_rnd = {1'b0, w_frac} + {23'd0, w_up};
    // A carry out of the fraction leaves frac=0 and bumps the exponent by one.
    assign w_exp      = 8'd158 - {3'd0, r_cnt} + {7'd0, w_frac_rnd[23]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_mag         <= '0;
            r_cnt         <= '0;
            r_sign        <= 1'b0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_inexact <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_sign     <= bus.in_signed & bus.in_data[31];
                        r_mag      <= (bus.in_signed & bus.in_data[31]) ? (~bus.in_data + 32'd1)
                                                                        : bus.in_data;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= NORM;
                    end
                end
                NORM: begin
                    if (r_mag == '0) begin
                        r_out_data    <= '0;
                        r_out_inexact <= 1'b0;
                        r_state       <= DONE;
                    end else if (r_mag[31]) begin
                        r_state <= ROUND;
                    end else if (w_coarse) begin
                        r_mag <= r_mag << SHIFT_STEP;
                        r_cnt <= r_cnt + STEP;
                    end else begin
                        r_mag <= r_mag << 1;
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                ROUND: begin
                    r_out_data    <= {r_sign, w_exp, w_frac_rnd[22:0]};
                    r_out_inexact <= w_guard | w_sticky;
                    r_state       <= DONE;
                end
                DONE: begin
                    // out_valid is raised one edge after entering DONE; results held until taken.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_out_data;
    assign bus.out_inexact = r_out_inexact;
endmodule

// File: tb/tb_int_to_fp32_seq.sv
// Bench for int_to_fp32_seq: SHIFT_STEP=1 and SHIFT_STEP=8 instances driven in lockstep,
// directed vectors, backpressure/reset sequences and random vectors against an arithmetic model.
module tb_int_to_fp32_seq;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_signed;
    logic        out_ready;

    int n_chk;
    int n_err;

    int_to_fp32_seq_if b1();
    int_to_fp32_seq_if b8();

    assign b1.in_valid  = in_valid;
    assign b1.in_data   = in_data;
    assign b1.in_signed = in_signed;
    assign b1.out_ready = out_ready;
    assign b8.in_valid  = in_valid;
    assign b8.in_data   = in_data;
    assign b8.in_signed = in_signed;
    assign b8.out_ready = out_ready;

    int_to_fp32_seq #(.SHIFT_STEP(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    int_to_fp32_seq #(.SHIFT_STEP(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        sg;
        logic [31:0] f;
        logic        ix;
        int          lat;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: locate the MSB, then round the dropped bits to nearest-even on integers.
    function automatic void model(input logic [31:0] d, input logic sg, input int step,
                                  output logic [31:0] f, output logic ix, output int lat);
        longint unsigned m, q, rem, half;
        logic neg;
        int p, e, lz, drop;
        neg = sg && d[31];
        m   = neg ? (64'h1_0000_0000 - {32'd0, d}) : {32'd0, d};
        if (m == 0) begin
            f = 32'd0; ix = 1'b0; lat = 2;
            return;
        end
        p = 0;
        for (int i = 0; i < 32; i++) if (((m >> i) & 64'd1) != 0) p = i;
        lz  = 31 - p;
        lat = lz / step + lz % step + 3;
        e   = 127 + p;
        rem = 0;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            drop = p - 23;
            q    = m >> drop;
            rem  = m & ((64'd1 << drop) - 64'd1);
            half = 64'd1 << (drop - 1);
            if (rem > half || (rem == half && (q & 64'd1) != 0)) q = q + 1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
        end
        ix = (rem != 0);
        f  = {neg, 8'(e), 23'(q)};
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(b1.in_ready && b8.in_ready) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 60) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // One conversion on both instances; caller sits #1 after a rising edge.
    task automatic run_and_check(input string tag, input logic [31:0] d, input logic sg,
                                 input logic [31:0] ef, input logic eix, input int elat1);
        logic [31:0] f1, f8, mf;
        logic ix1, ix8, mix;
        int lat1, lat8, elat8, n;
        bit got1, got8;
        model(d, sg, 8, mf, mix, elat8);
        wait_idle();
        in_data = d; in_signed = sg; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        got1 = 0; got8 = 0; n = 0;
        lat1 = -1; lat8 = -1; f1 = 'x; f8 = 'x; ix1 = 'x; ix8 = 'x;
        while (!(got1 && got8) && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (!got1 && b1.out_valid) begin got1 = 1; lat1 = n; f1 = b1.out_data; ix1 = b1.out_inexact; end
            if (!got8 && b8.out_valid) begin got8 = 1; lat8 = n; f8 = b8.out_data; ix8 = b8.out_inexact; end
        end
        if (!(got1 && got8)) chk({tag, "_timeout"}, 32'd1, 32'd0);
        chk({tag, "_data1"}, f1, ef);
        chk({tag, "_inex1"}, {31'd0, ix1}, {31'd0, eix});
        chk({tag, "_lat1"}, 32'(lat1), 32'(elat1));
        chk({tag, "_data8"}, f8, ef);
        chk({tag, "_inex8"}, {31'd0, ix8}, {31'd0, eix});
        chk({tag, "_lat8"}, 32'(lat8), 32'(elat8));
    endtask

    initial begin
        logic [31:0] mf, held1, held8, d;
        logic mix, sg;
        int mlat, bad, n;
        n_chk = 0; n_err = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_signed = 1'b0; out_ready = 1'b0;

        tbl[0]  = '{32'h0000_0001, 1'b0, 32'h3F80_0000, 1'b0, 34};
        tbl[1]  = '{32'hFFFF_FFFB, 1'b1, 32'hC0A0_0000, 1'b0, 32};
        tbl[2]  = '{32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0, 3};
        tbl[3]  = '{32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 2};
        tbl[4]  = '{32'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1, 10};
        tbl[5]  = '{32'h0100_0003, 1'b0, 32'h4B80_0002, 1'b1, 10};
        tbl[6]  = '{32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 1'b1, 3};
        tbl[7]  = '{32'h00FF_FFFF, 1'b0, 32'h4B7F_FFFF, 1'b0, 11};
        tbl[8]  = '{32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 1'b0, 34};
        tbl[9]  = '{32'h8000_0000, 1'b0, 32'h4F00_0000, 1'b0, 3};
        tbl[10] = '{32'h0000_0064, 1'b1, 32'h42C8_0000, 1'b0, 28};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, b1.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, b1.out_valid | b8.out_valid}, 32'd0);
        chk("rst_out_data", b1.out_data | b8.out_data, 32'd0);
        chk("rst_inexact", {31'd0, b1.out_inexact | b8.out_inexact}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) run_and_check($sformatf("vec%0d", i), tbl[i].d, tbl[i].sg, tbl[i].f, tbl[i].ix, tbl[i].lat);

        // Backpressure: result must hold while out_ready is low.
        wait_idle();
        in_data = 32'h1234_5678; in_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!b1.out_valid && n < 60) begin @(posedge clk); #1; n++; end
        chk("bp_valid_seen", {31'd0, b1.out_valid & b8.out_valid}, 32'd1);
        model(32'h1234_5678, 1'b0, 1, mf, mix, mlat);
        chk("bp_data", b1.out_data, mf);
        held1 = b1.out_data; held8 = b8.out_data; bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (!b1.out_valid || !b8.out_valid || b1.in_ready || b8.in_ready ||
                b1.out_data !== held1 || b8.out_data !== held8) bad++;
        end
        chk("bp_stable", 32'(bad), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_in_ready", {30'd0, b1.in_ready, b8.in_ready}, 32'd3);
        chk("bp_valid_drop", {30'd0, b1.out_valid, b8.out_valid}, 32'd0);
        run_and_check("b2b3", 32'd3, 1'b0, 32'h4040_0000, 1'b0, 33);
        run_and_check("b2b7", 32'd7, 1'b0, 32'h40E0_0000, 1'b0, 32);

        // Asynchronous reset in the middle of normalisation.
        wait_idle();
        in_data = 32'd1; in_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {30'd0, b1.out_valid, b8.out_valid}, 32'd0);
        chk("mid_rst_data", b1.out_data | b8.out_data, 32'd0);
        chk("mid_rst_in_ready", {30'd0, b1.in_ready, b8.in_ready}, 32'd3);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (b1.out_valid || b8.out_valid) bad++;
        end
        chk("post_rst_no_valid", 32'(bad), 32'd0);
        run_and_check("post_rst_100", 32'd100, 1'b1, 32'h42C8_0000, 1'b0, 28);

        for (int i = 0; i < 150; i++) begin
            d  = $urandom() >> $urandom_range(0, 31);
            sg = 1'($urandom_range(0, 1));
            if (i % 3 == 0) d = $urandom();
            model(d, sg, 1, mf, mix, mlat);
            run_and_check($sformatf("rnd%0d_%h_%0d", i, d, sg), d, sg, mf, mix, mlat);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
